// File: rtl/arm_shift_pkg.sv
// Shift encodings and shifter_operand field positions shared by the operand-2 pipeline.
package arm_shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  localparam int SO_ROT_MSB   = 11;
  localparam int SO_ROT_LSB   = 8;
  localparam int SO_IMM8_MSB  = 7;
  localparam int SO_IMM8_LSB  = 0;
  localparam int SO_SHAMT_MSB = 11;
  localparam int SO_SHAMT_LSB = 7;
  localparam int SO_TYPE_MSB  = 6;
  localparam int SO_TYPE_LSB  = 5;

endpackage

// File: rtl/shift_core.sv
// Single-cycle barrel shifter with ARM register-shift boundary semantics plus RRX.
module shift_core
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  shift_t           shift_type,
  input  logic [7:0]       amount,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  input  logic             is_rrx,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int         AW = $clog2(WIDTH);
  localparam logic [7:0] W8 = 8'(WIDTH);

  logic [AW-1:0]  n;
  logic [AW-1:0]  n_neg;
  logic [WIDTH:0] wide;

  assign n     = amount[AW-1:0];
  assign n_neg = -n;

  // A guard bit next to the operand captures the last bit shifted out.
  always_comb begin
    result = operand;
    carry  = carry_in;
    wide   = '0;
    if (is_rrx) begin
      result = {carry_in, operand[WIDTH-1:1]};
      carry  = operand[0];
    end else if (amount == 8'd0) begin
      result = operand;
      carry  = carry_in;
    end else begin
      case (shift_type)
        LSL: begin
          if (amount < W8) begin
            wide   = {1'b0, operand} << n;
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
          end else if (amount == W8) begin
            result = '0;
            carry  = operand[0];
          end else begin
            result = '0;
            carry  = 1'b0;
          end
        end
        LSR: begin
          if (amount < W8) begin
            wide   = {operand, 1'b0} >> n;
            result = wide[WIDTH:1];
            carry  = wide[0];
          end else if (amount == W8) begin
            result = '0;
            carry  = operand[WIDTH-1];
          end else begin
            result = '0;
            carry  = 1'b0;
          end
        end
        ASR: begin
          if (amount < W8) begin
            wide   = $signed({operand, 1'b0}) >>> n;
            result = wide[WIDTH:1];
            carry  = wide[0];
          end else begin
            result = {WIDTH{operand[WIDTH-1]}};
            carry  = operand[WIDTH-1];
          end
        end
        ROR: begin
          result = (operand >> n) | (operand << n_neg);
          carry  = result[WIDTH-1];
        end
        default: begin
          result = operand;
          carry  = carry_in;
        end
      endcase
    end
  end

endmodule

// File: rtl/operand2_shift_pipe.sv
// Two-stage operand-2 generator: stage A holds the decoded shift request, stage B holds val2/carry.
module operand2_shift_pipe
  import arm_shift_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit MEM_SIGN_EXT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_inst,
  input  logic             imm,
  input  logic             reg_shift,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [7:0]       val_rs,
  input  logic [11:0]      shifter_operand,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val2,
  output logic             carry_out
);

  shift_t           a_type_q, a_type_d, dec_type, so_type;
  logic [7:0]       a_amt_q, a_amt_d, dec_amt;
  logic [WIDTH-1:0] a_op_q, a_op_d, dec_op;
  logic             a_cin_q, a_cin_d, a_rrx_q, a_rrx_d, dec_rrx;
  logic             a_valid_q, a_valid_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] val2_q, val2_d, core_res;
  logic             carry_q, carry_d, core_c;
  logic [4:0]       shamt;
  logic             b_load, accept;

  assign b_load    = !out_valid_q || out_ready;
  assign in_ready  = !a_valid_q || b_load;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_q;
  assign val2      = val2_q;
  assign carry_out = carry_q;

  // Every instruction form maps onto one uniform barrel request; immediate #0 encodings resolve here.
  always_comb begin
    shamt    = shifter_operand[SO_SHAMT_MSB:SO_SHAMT_LSB];
    so_type  = shift_t'(shifter_operand[SO_TYPE_MSB:SO_TYPE_LSB]);
    dec_type = so_type;
    dec_amt  = 8'd0;
    dec_op   = val_rm;
    dec_rrx  = 1'b0;
    if (mem_inst) begin
      dec_type = LSL;
      dec_op   = MEM_SIGN_EXT ? {{(WIDTH-12){shifter_operand[11]}}, shifter_operand}
                              : {{(WIDTH-12){1'b0}}, shifter_operand};
    end else if (imm) begin
      dec_type = ROR;
      dec_amt  = {3'b000, shifter_operand[SO_ROT_MSB:SO_ROT_LSB], 1'b0};
      dec_op   = {{(WIDTH-8){1'b0}}, shifter_operand[SO_IMM8_MSB:SO_IMM8_LSB]};
    end else if (reg_shift) begin
      dec_amt = val_rs;
    end else if (shamt != 5'd0) begin
      dec_amt = {3'b000, shamt};
    end else begin
      case (so_type)
        LSR, ASR: dec_amt = 8'd32;
        ROR:      dec_rrx = 1'b1;
        default:  dec_amt = 8'd0;
      endcase
    end
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .shift_type (a_type_q),
    .amount     (a_amt_q),
    .operand    (a_op_q),
    .carry_in   (a_cin_q),
    .is_rrx     (a_rrx_q),
    .result     (core_res),
    .carry      (core_c)
  );

  // Next-state for both stages; stage B only moves when its slot is free or being drained.
  always_comb begin
    a_type_d = a_type_q;
    a_amt_d  = a_amt_q;
    a_op_d   = a_op_q;
    a_cin_d  = a_cin_q;
    a_rrx_d  = a_rrx_q;
    if (accept) begin
      a_type_d = dec_type;
      a_amt_d  = dec_amt;
      a_op_d   = dec_op;
      a_cin_d  = carry_in;
      a_rrx_d  = dec_rrx;
    end else begin
      a_op_d   = a_op_q;
    end
    if (flush) begin
      a_valid_d = 1'b0;
    end else if (in_ready) begin
      a_valid_d = in_valid;
    end else begin
      a_valid_d = a_valid_q;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (b_load) begin
      out_valid_d = a_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (b_load && a_valid_q) begin
      val2_d  = core_res;
      carry_d = core_c;
    end else begin
      val2_d  = val2_q;
      carry_d = carry_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_type_q    <= LSL;
      a_amt_q     <= 8'd0;
      a_op_q      <= '0;
      a_cin_q     <= 1'b0;
      a_rrx_q     <= 1'b0;
      a_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      val2_q      <= '0;
      carry_q     <= 1'b0;
    end else begin
      a_type_q    <= a_type_d;
      a_amt_q     <= a_amt_d;
      a_op_q      <= a_op_d;
      a_cin_q     <= a_cin_d;
      a_rrx_q     <= a_rrx_d;
      a_valid_q   <= a_valid_d;
      out_valid_q <= out_valid_d;
      val2_q      <= val2_d;
      carry_q     <= carry_d;
    end
  end

endmodule

// File: tb/tb_operand2_shift_pipe.sv
// Drives a 32-bit sign-extending and a 64-bit zero-extending instance with shared stimulus;
// a monitor thread scores every output against a bit-serial reference model.
module tb_operand2_shift_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, mem_inst, imm, reg_shift, carry_in, out_ready;
  logic [63:0] val_rm;
  logic [7:0]  val_rs;
  logic [11:0] shifter_operand;
  logic        in_ready32, out_valid32, carry32;
  logic [31:0] val2_32;
  logic        in_ready64, out_valid64, carry64;
  logic [63:0] val2_64;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] q32[$];
  logic [64:0] q64[$];
  bit          dir_has, rr, st32, st64;
  logic [32:0] dir_exp, sv32;
  logic [64:0] sv64;

  always #5 clk = ~clk;

  operand2_shift_pipe #(.WIDTH(32), .MEM_SIGN_EXT(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .mem_inst(mem_inst), .imm(imm), .reg_shift(reg_shift), .val_rm(val_rm[31:0]),
    .val_rs(val_rs), .shifter_operand(shifter_operand), .carry_in(carry_in),
    .out_valid(out_valid32), .out_ready(out_ready), .val2(val2_32), .carry_out(carry32)
  );

  operand2_shift_pipe #(.WIDTH(64), .MEM_SIGN_EXT(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .mem_inst(mem_inst), .imm(imm), .reg_shift(reg_shift), .val_rm(val_rm),
    .val_rs(val_rs), .shifter_operand(shifter_operand), .carry_in(carry_in),
    .out_valid(out_valid64), .out_ready(out_ready), .val2(val2_64), .carry_out(carry64)
  );

  // Returns {carry, value}; shifts are applied one bit at a time, carry = last bit pushed out.
  function automatic logic [64:0] ref_model(input int w, input bit sext, input bit m, input bit im,
                                            input bit rsh, input logic [63:0] rm, input logic [7:0] rs,
                                            input logic [11:0] so, input bit cin);
    logic [63:0] mask, v;
    logic [1:0]  t;
    bit          c, sb;
    int          n;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    v = rm & mask;
    c = cin;
    t = so[6:5];
    if (m) begin
      v = {52'd0, so};
      if (sext && so[11]) v = v | (mask & ~64'h0000_0000_0000_0FFF);
    end else if (im) begin
      v = {56'd0, so[7:0]};
      n = 2 * int'(so[11:8]);
      for (int k = 0; k < n; k++) v = ((v >> 1) | ({63'd0, v[0]} << (w - 1))) & mask;
      if (n != 0) c = v[w-1];
    end else if (!rsh && so[11:7] == 5'd0 && t == 2'b11) begin
      c = v[0];
      v = (v >> 1) | ({63'd0, cin} << (w - 1));
    end else begin
      if (rsh) n = int'(rs);
      else if (so[11:7] == 5'd0 && (t == 2'b01 || t == 2'b10)) n = 32;
      else n = int'(so[11:7]);
      for (int k = 0; k < n; k++) begin
        sb = v[w-1];
        case (t)
          2'b00:   begin c = v[w-1]; v = (v << 1) & mask; end
          2'b01:   begin c = v[0];   v = v >> 1; end
          2'b10:   begin c = v[0];   v = (v >> 1) | ({63'd0, sb} << (w - 1)); end
          default: begin c = v[0];   v = (v >> 1) | ({63'd0, v[0]} << (w - 1)); end
        endcase
      end
    end
    return {c, v};
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor_cycle();
    logic [64:0] m;
    if (st32) chk("hold32", {out_valid32, carry32, val2_32}, {1'b1, sv32});
    if (st64) chk("hold64", {out_valid64, carry64, val2_64}, {1'b1, sv64});
    st32 = (out_valid32 === 1'b1) && !out_ready && !flush && !rst;
    st64 = (out_valid64 === 1'b1) && !out_ready && !flush && !rst;
    sv32 = {carry32, val2_32};
    sv64 = {carry64, val2_64};
    if (out_valid32 === 1'b1 && out_ready && !rst) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected32: got output %h with no pending entry, expected none", val2_32);
      end else chk("data32", {carry32, val2_32}, q32.pop_front());
    end
    if (out_valid64 === 1'b1 && out_ready && !rst) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected64: got output %h with no pending entry, expected none", val2_64);
      end else chk("data64", {carry64, val2_64}, q64.pop_front());
    end
    if (rst || flush) begin
      q32.delete();
      q64.delete();
    end
    if (in_valid && !flush && !rst) begin
      if (in_ready32 === 1'b1) begin
        m = ref_model(32, 1'b1, mem_inst, imm, reg_shift, val_rm, val_rs, shifter_operand, carry_in);
        q32.push_back(dir_has ? dir_exp : {m[64], m[31:0]});
      end
      if (in_ready64 === 1'b1)
        q64.push_back(ref_model(64, 1'b0, mem_inst, imm, reg_shift, val_rm, val_rs, shifter_operand, carry_in));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rr) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_in(input bit m, input bit i, input bit r, input logic [63:0] rm,
                        input logic [7:0] rs, input logic [11:0] so, input bit c);
    mem_inst = m; imm = i; reg_shift = r; val_rm = rm; val_rs = rs; shifter_operand = so; carry_in = c;
  endtask

  task automatic set_rand();
    int sel;
    logic [7:0] rs;
    case ($urandom_range(0, 5))
      0:       rs = 8'd0;
      1:       rs = 8'd32;
      2:       rs = 8'd64;
      3:       rs = 8'($urandom_range(30, 34));
      4:       rs = 8'($urandom_range(62, 66));
      default: rs = 8'($urandom);
    endcase
    sel = $urandom_range(0, 9);
    set_in(sel == 0, sel == 1 || sel == 2, sel >= 3 && sel <= 6,
           {32'($urandom), 32'($urandom)}, rs, 12'($urandom), 1'($urandom));
    dir_has = 1'b0;
  endtask

  task automatic send();
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready32 === 1'b1 && !flush && !rst) begin
        cyc();
        in_valid = 1'b0;
        dir_has  = 1'b0;
        return;
      end
      cyc();
    end
    checks++; errors++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 64 cycles");
    in_valid = 1'b0;
  endtask

  task automatic dsend(input bit m, input bit i, input bit r, input logic [63:0] rm,
                       input logic [7:0] rs, input logic [11:0] so, input bit c, input logic [32:0] x);
    set_in(m, i, r, rm, rs, so, c);
    dir_has = 1'b1;
    dir_exp = x;
    send();
  endtask

  task automatic drain();
    rr = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (q32.size() != 0 || q64.size() != 0); k++) cyc();
    repeat (3) cyc();
    chk("drain32", 66'(q32.size()), 66'd0);
    chk("drain64", 66'(q64.size()), 66'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rr = 1'b0;
    dir_has = 1'b0; dir_exp = '0; st32 = 1'b0; st64 = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 64'd0, 8'd0, 12'd0, 1'b0);
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset32", {out_valid32, carry32, val2_32, in_ready32}, {1'b0, 1'b0, 32'd0, 1'b1});
    chk("reset64", {out_valid64, carry64, val2_64}, {1'b0, 1'b0, 64'd0});
    chk("reset_rdy64", 66'(in_ready64), 66'd1);
    cyc();

    dsend(1'b0, 1'b1, 1'b0, 64'd0, 8'd0, 12'h4FF, 1'b0, {1'b1, 32'hFF00_0000});
    dsend(1'b0, 1'b1, 1'b0, 64'd0, 8'd0, 12'h0FF, 1'b1, {1'b1, 32'h0000_00FF});
    dsend(1'b0, 1'b0, 1'b0, 64'h8000_0000_8000_0001, 8'd0, 12'h020, 1'b0, {1'b1, 32'h0000_0000});
    dsend(1'b0, 1'b0, 1'b0, 64'h8000_0000_8000_0001, 8'd0, 12'h040, 1'b0, {1'b1, 32'hFFFF_FFFF});
    dsend(1'b0, 1'b0, 1'b0, 64'h8000_0000_8000_0001, 8'd0, 12'h060, 1'b1, {1'b1, 32'hC000_0000});
    dsend(1'b0, 1'b0, 1'b0, 64'h0000_0000_8000_0001, 8'd0, 12'h200, 1'b1, {1'b0, 32'h0000_0010});
    dsend(1'b0, 1'b0, 1'b0, 64'h0000_0000_1234_5678, 8'd0, 12'h000, 1'b1, {1'b1, 32'h1234_5678});
    dsend(1'b0, 1'b0, 1'b1, 64'h8000_0000_8000_0001, 8'd32, 12'h010, 1'b0, {1'b1, 32'h0000_0000});
    dsend(1'b0, 1'b0, 1'b1, 64'h8000_0000_8000_0001, 8'd33, 12'h010, 1'b1, {1'b0, 32'h0000_0000});
    dsend(1'b0, 1'b0, 1'b1, 64'h8000_0000_8000_0001, 8'd64, 12'h070, 1'b0, {1'b1, 32'h8000_0001});
    dsend(1'b0, 1'b0, 1'b1, 64'h8000_0000_8000_0001, 8'd0, 12'h030, 1'b0, {1'b0, 32'h8000_0001});
    dsend(1'b1, 1'b1, 1'b0, 64'd0, 8'd0, 12'h800, 1'b1, {1'b1, 32'hFFFF_F800});
    drain();

    // Backpressure: out_ready low for three stall cycles while four inputs queue up.
    begin
      int idx;
      idx = 0;
      out_ready = 1'b0;
      set_rand();
      in_valid = 1'b1;
      for (int c = 0; c < 40 && (idx < 4 || q32.size() != 0); c++) begin
        @(negedge clk);
        if (c <= 4) chk($sformatf("bp_ready_c%0d", c), 66'(in_ready32), 66'(c < 2));
        if (in_valid && in_ready32 === 1'b1) idx++;
        cyc();
        out_ready = (c >= 4);
        if (idx < 4) set_rand();
        else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      chk("bp_accepts", 66'(idx), 66'd4);
    end
    drain();

    // Flush with both stages occupied; an input offered in the flush cycle is dropped.
    out_ready = 1'b0;
    set_rand(); send();
    set_rand(); send();
    set_rand();
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_ov", {out_valid32, out_valid64}, 66'd0);
    chk("flush_ready", 66'(in_ready32), 66'd1);
    drain();

    // Reset mid-stream with an input presented.
    out_ready = 1'b0;
    set_rand(); send();
    set_rand(); send();
    set_rand();
    in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out32", {out_valid32, val2_32}, 66'd0);
    chk("rst_out64", {out_valid64, val2_64}, 66'd0);
    drain();

    rr = 1'b1;
    repeat (300) begin
      set_rand();
      send();
      if ($urandom_range(0, 4) == 0) cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
